pipe_hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core: forwarding selects for the EX operand muxes, load-use

---
 rtl/pipe_hazard_ctrl.sv | 173 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard sequencer for the 5-stage core: EX operand forwarding, load-use stalls,
// branch/trap flushes and LSU back-pressure. Define PIPE_CTRL_MD_EN to add the mul/div handshake.
`timescale 1ns / 1ps

module pipe_hazard_ctrl #(
    parameter int RF_AW      = 5,
    parameter int MD_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_rs1_rd_i,
    input  logic             id_rs2_rd_i,
    input  logic [RF_AW-1:0] id_rs1_addr_i,
    input  logic [RF_AW-1:0] id_rs2_addr_i,
    input  logic             id_reg_wen_i,
    input  logic [RF_AW-1:0] id_reg_waddr_i,
    input  logic             id_mem_rd_i,
    input  logic             id_md_instr_i,
    input  logic             ex_take_branch_i,
    input  logic             mem_exception_i,
    input  logic             trap_ack_i,
    input  logic             lsu_busy_i,
    input  logic             md_done_i,
    output logic             md_start_o,
    output logic             md_timeout_o,
    output logic             op1_fwd_mem_o,
    output logic             op1_fwd_wb_o,
    output logic             op2_fwd_mem_o,
    output logic             op2_fwd_wb_o,
    output logic             if_stall_o,
    output logic             id_stall_o,
    output logic             ex_stall_o,
    output logic             id_flush_o,
    output logic             if_flush_o,
    output logic             mem_flush_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_TRAP    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             rst_dly_q;
    logic             ex_wen_q, ex_load_q, mem_wen_q;
    logic [RF_AW-1:0] ex_waddr_q, mem_waddr_q;

    logic out_en, in_trap, in_wait;
    logic md_release, md_expire, md_start;
    logic exc_now, trap_flush, branch, hold, load_use;
    logic id_flush, ex_stall, fwd_ok;
    logic rs1_ex_hit, rs2_ex_hit, rs1_mem_hit, rs2_mem_hit;

    // Outputs stay quiet during reset and for the first cycle after it.
    assign out_en  = !rst && !rst_dly_q;
    assign in_trap = out_en && (state_q == ST_TRAP);

`ifdef PIPE_CTRL_MD_EN
    localparam int CNT_W = $clog2(MD_TIMEOUT + 1);

    logic [CNT_W-1:0] md_cnt_q;
    logic             in_run;

    assign in_run     = out_en && (state_q == ST_RUN);
    assign in_wait    = out_en && (state_q == ST_MD_WAIT);
    assign md_release = in_wait && md_done_i;
    assign md_expire  = in_wait && !md_done_i && (md_cnt_q == CNT_W'(MD_TIMEOUT));
    assign md_start   = in_run && id_md_instr_i && !hold && !load_use && !id_flush;

    // Counts MD_WAIT cycles; reads zero on the first cycle of every wait.
    always_ff @(posedge clk) begin
        if (rst) begin
            md_cnt_q <= '0;
        end else if (state_q == ST_MD_WAIT) begin
            md_cnt_q <= md_cnt_q + CNT_W'(1);
        end else begin
            md_cnt_q <= '0;
        end
    end
`else
    localparam int unused_md_timeout = MD_TIMEOUT;
    logic          unused_md_inputs;

    assign unused_md_inputs = id_md_instr_i | md_done_i;
    assign in_wait          = 1'b0;
    assign md_release       = 1'b0;
    assign md_expire        = 1'b0;
    assign md_start         = 1'b0;
`endif

    // A timeout is handled exactly like a MEM-stage exception.
    assign exc_now    = out_en && !in_trap && (mem_exception_i || md_expire);
    assign trap_flush = in_trap || exc_now;
    assign branch     = out_en && !trap_flush && ex_take_branch_i;
    assign hold       = out_en && !trap_flush && (lsu_busy_i || (in_wait && !md_release));

    // Register x0 is never a producer, so a zero index never matches.
    assign rs1_ex_hit  = id_rs1_rd_i && ex_wen_q  && (ex_waddr_q  != '0) && (ex_waddr_q  == id_rs1_addr_i);
    assign rs2_ex_hit  = id_rs2_rd_i && ex_wen_q  && (ex_waddr_q  != '0) && (ex_waddr_q  == id_rs2_addr_i);
    assign rs1_mem_hit = id_rs1_rd_i && mem_wen_q && (mem_waddr_q != '0) && (mem_waddr_q == id_rs1_addr_i);
    assign rs2_mem_hit = id_rs2_rd_i && mem_wen_q && (mem_waddr_q != '0) && (mem_waddr_q == id_rs2_addr_i);

    assign load_use = out_en && !trap_flush && !branch && !hold && ex_load_q && (rs1_ex_hit || rs2_ex_hit);

    assign id_flush = trap_flush || branch || load_use;
    assign ex_stall = hold;
    assign fwd_ok   = out_en && !id_flush;

    assign md_start_o    = md_start;
    assign md_timeout_o  = md_expire;
    assign op1_fwd_mem_o = fwd_ok && rs1_ex_hit;
    assign op1_fwd_wb_o  = fwd_ok && rs1_mem_hit && !rs1_ex_hit;
    assign op2_fwd_mem_o = fwd_ok && rs2_ex_hit;
    assign op2_fwd_wb_o  = fwd_ok && rs2_mem_hit && !rs2_ex_hit;
    assign if_stall_o    = hold || load_use;
    assign id_stall_o    = hold || load_use;
    assign ex_stall_o    = ex_stall;
    assign id_flush_o    = id_flush;
    assign if_flush_o    = trap_flush || branch;
    assign mem_flush_o   = trap_flush;

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (exc_now) begin
                    state_d = ST_TRAP;
                end else if (md_start) begin
                    state_d = ST_MD_WAIT;
                end
            end
            ST_MD_WAIT: begin
                if (exc_now) begin
                    state_d = ST_TRAP;
                end else if (md_release) begin
                    state_d = ST_RUN;
                end
            end
            ST_TRAP: begin
                if (out_en && trap_ack_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            rst_dly_q   <= 1'b1;
            ex_wen_q    <= 1'b0;
            ex_waddr_q  <= '0;
            ex_load_q   <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_waddr_q <= '0;
        end else begin
            state_q   <= state_d;
            rst_dly_q <= 1'b0;
            if (!ex_stall) begin
                mem_wen_q   <= ex_wen_q;
                mem_waddr_q <= ex_waddr_q;
                ex_wen_q    <= !id_flush && id_reg_wen_i;
                ex_waddr_q  <= id_flush ? '0 : id_reg_waddr_i;
                ex_load_q   <= !id_flush && id_mem_rd_i;
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected output vectors are queued as each cycle's
// stimulus is driven and compared at the following falling edge.
`timescale 1ns / 1ps

module tb_pipe_hazard_ctrl;

    // Output vector bit order: md_start md_timeout op1m op1w op2m op2w ifs ids exs idf iff memf
    localparam logic [11:0] E_NONE = 12'h000;
    localparam logic [11:0] E_MDS  = 12'h800;
    localparam logic [11:0] E_MDT  = 12'h400;
    localparam logic [11:0] E_O1M  = 12'h200;
    localparam logic [11:0] E_O1W  = 12'h100;
    localparam logic [11:0] E_O2M  = 12'h080;
    localparam logic [11:0] E_O2W  = 12'h040;
    localparam logic [11:0] E_LU   = 12'h034;
    localparam logic [11:0] E_HOLD = 12'h038;
    localparam logic [11:0] E_BR   = 12'h006;
    localparam logic [11:0] E_TRAP = 12'h007;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_rs1_rd, id_rs2_rd, id_reg_wen, id_mem_rd, id_md_instr;
    logic [4:0] id_rs1_addr, id_rs2_addr, id_reg_waddr;
    logic       ex_take_branch, mem_exception, trap_ack, lsu_busy, md_done;
    logic       md_start, md_timeout, op1_fwd_mem, op1_fwd_wb, op2_fwd_mem, op2_fwd_wb;
    logic       if_stall, id_stall, ex_stall, id_flush, if_flush, mem_flush;
    logic [11:0] obs;

    int          errors = 0;
    int          checks = 0;
    string       tag_q[$];
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.RF_AW(5), .MD_TIMEOUT(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .id_rs1_rd_i      (id_rs1_rd),
        .id_rs2_rd_i      (id_rs2_rd),
        .id_rs1_addr_i    (id_rs1_addr),
        .id_rs2_addr_i    (id_rs2_addr),
        .id_reg_wen_i     (id_reg_wen),
        .id_reg_waddr_i   (id_reg_waddr),
        .id_mem_rd_i      (id_mem_rd),
        .id_md_instr_i    (id_md_instr),
        .ex_take_branch_i (ex_take_branch),
        .mem_exception_i  (mem_exception),
        .trap_ack_i       (trap_ack),
        .lsu_busy_i       (lsu_busy),
        .md_done_i        (md_done),
        .md_start_o       (md_start),
        .md_timeout_o     (md_timeout),
        .op1_fwd_mem_o    (op1_fwd_mem),
        .op1_fwd_wb_o     (op1_fwd_wb),
        .op2_fwd_mem_o    (op2_fwd_mem),
        .op2_fwd_wb_o     (op2_fwd_wb),
        .if_stall_o       (if_stall),
        .id_stall_o       (id_stall),
        .ex_stall_o       (ex_stall),
        .id_flush_o       (id_flush),
        .if_flush_o       (if_flush),
        .mem_flush_o      (mem_flush)
    );

    assign obs = {md_start, md_timeout, op1_fwd_mem, op1_fwd_wb, op2_fwd_mem, op2_fwd_wb,
                  if_stall, id_stall, ex_stall, id_flush, if_flush, mem_flush};

    task automatic idle();
        id_rs1_rd      = 1'b0;
        id_rs2_rd      = 1'b0;
        id_rs1_addr    = 5'd0;
        id_rs2_addr    = 5'd0;
        id_reg_wen     = 1'b0;
        id_reg_waddr   = 5'd0;
        id_mem_rd      = 1'b0;
        id_md_instr    = 1'b0;
        ex_take_branch = 1'b0;
        mem_exception  = 1'b0;
        trap_ack       = 1'b0;
        lsu_busy       = 1'b0;
        md_done        = 1'b0;
    endtask

    task automatic id_instr(input logic r1, input logic [4:0] a1, input logic r2,
                            input logic [4:0] a2, input logic wen, input logic [4:0] wa,
                            input logic ld);
        idle();
        id_rs1_rd    = r1;
        id_rs1_addr  = a1;
        id_rs2_rd    = r2;
        id_rs2_addr  = a2;
        id_reg_wen   = wen;
        id_reg_waddr = wa;
        id_mem_rd    = ld;
    endtask

    task automatic compare();
        string       t;
        logic [11:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard: observed=%03h with no expectation queued", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed=%03h expected=%03h", t, obs, e);
            end
        end
    endtask

    // Inputs are set just after a rising edge; the expectation is checked at the falling edge.
    task automatic step(input string tag, input logic [11:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1;
        // Reset: everything quiet while rst is high and for one cycle after.
        mem_exception = 1'b1;
        lsu_busy      = 1'b1;
        step("rst_active", E_NONE);
        rst = 1'b0;
        ex_take_branch = 1'b1;
        step("rst_release_cycle", E_NONE);

        // EX forwarding, MEM/WB forwarding and newer-producer priority.
        id_instr(1, 5'd1, 1, 5'd2, 1, 5'd5, 0);  step("add_x5_in_id", E_NONE);
        id_instr(1, 5'd5, 1, 5'd3, 1, 5'd7, 0);  step("fwd_mem_rs1", E_O1M);
        id_instr(1, 5'd5, 1, 5'd7, 1, 5'd5, 0);  step("fwd_wb_rs1_mem_rs2", E_O1W | E_O2M);
        id_instr(1, 5'd5, 1, 5'd7, 1, 5'd5, 0);  step("fwd_mem_rs1_wb_rs2", E_O1M | E_O2W);
        id_instr(1, 5'd5, 1, 5'd0, 0, 5'd0, 0);  step("newer_producer_wins", E_O1M);
        id_instr(0, 5'd5, 1, 5'd5, 0, 5'd0, 0);  step("rs_rd_gates_fwd", E_O2W);

        // x0 never forwards and never causes a load-use stall.
        id_instr(0, 5'd0, 0, 5'd0, 1, 5'd0, 1);  step("load_to_x0", E_NONE);
        id_instr(1, 5'd0, 1, 5'd0, 0, 5'd0, 0);  step("x0_read_ex", E_NONE);
        id_instr(1, 5'd0, 1, 5'd0, 0, 5'd0, 0);  step("x0_read_mem", E_NONE);

        // Load-use: one bubble cycle, then WB forwarding.
        id_instr(1, 5'd2, 0, 5'd0, 1, 5'd6, 1);  step("lw_x6_in_id", E_NONE);
        id_instr(1, 5'd1, 1, 5'd6, 1, 5'd8, 0);  step("load_use_bubble", E_LU);
        id_instr(1, 5'd1, 1, 5'd6, 1, 5'd8, 0);  step("load_use_then_wb", E_O2W);

        // Branch overrides load-use.
        id_instr(0, 5'd0, 0, 5'd0, 1, 5'd9, 1);  step("lw_x9_in_id", E_NONE);
        id_instr(1, 5'd9, 0, 5'd0, 0, 5'd0, 0);
        ex_take_branch = 1'b1;                   step("branch_over_load_use", E_BR);
        idle();                                  step("after_branch", E_NONE);

        // LSU back-pressure holds the trackers; branch during busy flushes and stalls.
        id_instr(0, 5'd0, 0, 5'd0, 1, 5'd11, 0); step("add_x11_in_id", E_NONE);
        id_instr(1, 5'd11, 0, 5'd0, 1, 5'd12, 0);
        lsu_busy = 1'b1;                         step("lsu_busy_hold", E_HOLD | E_O1M);
        lsu_busy = 1'b1;                         step("lsu_busy_trk_held", E_HOLD | E_O1M);
        ex_take_branch = 1'b1;                   step("branch_during_busy", E_HOLD | E_BR);
        lsu_busy = 1'b0;                         step("branch_busy_drops", E_BR);
        id_instr(1, 5'd11, 0, 5'd0, 0, 5'd0, 0); step("x11_reaches_wb", E_O1W);

        // Trap entry during busy, trap hold, ack, and reset from inside TRAP.
        idle();
        lsu_busy = 1'b1;
        mem_exception = 1'b1;                    step("exc_during_busy", E_TRAP);
        idle();
        lsu_busy = 1'b1;
        ex_take_branch = 1'b1;                   step("trap_holds", E_TRAP);
        idle();
        trap_ack = 1'b1;                         step("trap_ack_cycle", E_TRAP);
        idle();
        ex_take_branch = 1'b1;                   step("run_after_ack", E_BR);
        idle();
        mem_exception = 1'b1;                    step("exc_again", E_TRAP);
        idle();
        rst = 1'b1;                              step("rst_mid_trap", E_NONE);
        rst = 1'b0;
        ex_take_branch = 1'b1;                   step("rst_mid_trap_after", E_NONE);
        ex_take_branch = 1'b1;                   step("run_after_rst", E_BR);

`ifdef PIPE_CTRL_MD_EN
        // DIV: start pulse, 7 held stalls, release on md_done, then RUN again.
        idle();
        id_md_instr = 1'b1;
        id_reg_wen = 1'b1;
        id_reg_waddr = 5'd13;                    step("md_start", E_MDS);
        for (int i = 0; i < 7; i++) begin
            idle();
            id_md_instr = 1'b1;
            step($sformatf("md_wait_%0d", i), E_HOLD);
        end
        idle();
        md_done = 1'b1;                          step("md_done_release", E_NONE);
        idle();
        id_md_instr = 1'b1;                      step("md_start_again", E_MDS);
        for (int i = 0; i < 64; i++) begin
            idle();
            step($sformatf("md_to_wait_%0d", i), E_HOLD);
        end
        idle();                                  step("md_timeout_pulse", E_MDT | E_TRAP);
        idle();
        md_done = 1'b1;                          step("late_md_done_ignored", E_TRAP);
        idle();
        trap_ack = 1'b1;                         step("md_trap_ack", E_TRAP);
        idle();
        id_md_instr = 1'b1;                      step("md_start_third", E_MDS);
        idle();
        mem_exception = 1'b1;                    step("exc_abandons_md", E_TRAP);
        idle();
        md_done = 1'b1;
        id_md_instr = 1'b1;                      step("md_abandoned", E_TRAP);
        idle();
        trap_ack = 1'b1;                         step("md_abandon_ack", E_TRAP);
        idle();                                  step("md_back_to_run", E_NONE);
`else
        idle();
        id_md_instr = 1'b1;
        md_done = 1'b1;                          step("md_ignored", E_NONE);
        idle();
        id_md_instr = 1'b1;                      step("md_ignored_no_stall", E_NONE);
`endif

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: observed=%0d left expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
